// File: rtl/spi_burst_arbiter_pkg.sv
// Shared definitions for the SPI burst arbiter: FSM state encodings and counter sizing.
package spi_burst_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // Width of the shared CS timing counter, large enough for the biggest of setup/hold/gap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_burst_arbiter_rr_pick.sv
// Rotating-priority picker: first set request searching upward from i_ptr+1, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int unsigned w_j;

  // Scan from lowest to highest priority so the last hit (closest to ptr+1) wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      w_j = (32'(i_ptr) + k) % NREQ;
      if (i_req[w_j]) begin
        o_onehot = NREQ'(1) << w_j;
        o_idx    = IW'(w_j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one byte-level SPI engine between NREQ burst requesters, one chip select each,
// with programmable CS setup/hold/gap and round-robin arbitration between bursts.
module spi_burst_arbiter
  import spi_burst_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     req_tx_data,
  output logic [NREQ-1:0]       req_grant,
  output logic [NREQ-1:0]       req_tx_ready,
  output logic [NREQ-1:0]       req_rx_valid,
  output logic [7:0]            req_rx_data,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       cs_n,
  output logic                  eng_start,
  output logic [7:0]            eng_tx,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [7:0]            eng_rx
);

  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = cnt_width(CS_SETUP, CS_HOLD, CS_GAP);

  logic [2:0]       r_state;
  logic [IW-1:0]    r_g;
  logic [IW-1:0]    r_ptr;
  logic [LEN_W-1:0] r_bcnt;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [LEN_W-1:0] w_len_sel;
  logic [7:0]       w_tx_sel;
  logic             w_g_valid;
  logic [NREQ-1:0]  w_g_oh;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_onehot(w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_len_sel = req_len[32'(w_pick_idx)*LEN_W +: LEN_W];
  assign w_tx_sel  = req_tx_data[32'(r_g)*8 +: 8];
  assign w_g_valid = req_valid[r_g];
  assign w_g_oh    = NREQ'(1) << r_g;

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      r_state      <= ST_IDLE;
      r_g          <= '0;
      r_ptr        <= IW'(NREQ - 1);
      r_bcnt       <= '0;
      r_cnt        <= '0;
      cs_n         <= '1;
      req_grant    <= '0;
      req_tx_ready <= '0;
      req_rx_valid <= '0;
      req_rx_data  <= '0;
      req_done     <= '0;
      eng_start    <= 1'b0;
      eng_tx       <= '0;
    end else begin
      eng_start    <= 1'b0;
      req_tx_ready <= '0;
      req_rx_valid <= '0;
      req_done     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_g       <= w_pick_idx;
            r_bcnt    <= w_len_sel;
            req_grant <= w_pick_oh;
            cs_n      <= ~w_pick_oh;
            r_cnt     <= CNT_W'(CS_SETUP);
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else             r_state <= ST_START;
        end
        ST_START: begin
          if (!eng_busy) begin
            eng_start    <= 1'b1;
            eng_tx       <= w_tx_sel;
            req_tx_ready <= w_g_oh;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A dropped req_valid only ends the burst once the byte in flight has returned.
          if (eng_done) begin
            req_rx_data  <= eng_rx;
            req_rx_valid <= w_g_oh;
            if (r_bcnt == '0 || !w_g_valid) begin
              r_cnt   <= CNT_W'(CS_HOLD);
              r_state <= ST_HOLD;
            end else begin
              r_bcnt  <= r_bcnt - LEN_W'(1);
              r_state <= ST_START;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            cs_n      <= '1;
            req_grant <= '0;
            req_done  <= w_g_oh;
            r_ptr     <= r_g;
            r_cnt     <= CNT_W'(CS_GAP);
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else             r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
